// File: rtl/bsm_operand_serializer_if.sv
// Operand handshake and serial-stream bundle for bsm_operand_serializer.
// master: operand source side (drives operands, observes stream).
// slave:  serializer side.
interface bsm_operand_serializer_if #(
  parameter int unsigned MAXW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [MAXW-1:0] a_data;
  logic [MAXW-1:0] b_data;
  logic [4:0]      wa;
  logic [4:0]      wb;
  logic            start;
  logic [4:0]      wa_out;
  logic [4:0]      wb_out;
  logic            bit_a;
  logic            bit_b;
  logic            last;
  logic            busy;
  logic            err;

  modport master (
    output in_valid, a_data, b_data, wa, wb,
    input  in_ready, start, wa_out, wb_out, bit_a, bit_b, last, busy, err
  );

  modport slave (
    input  in_valid, a_data, b_data, wa, wb,
    output in_ready, start, wa_out, wb_out, bit_a, bit_b, last, busy, err
  );
endinterface

// File: rtl/bsm_operand_serializer.sv
// Bit-serial operand transmitter for the bit-serial multiplier.
// Accepts a signed operand pair with run-time widths, pulses start for one
// cycle, then streams both operands LSB-first for max(wa,wb) cycles with the
// shorter operand sign-extended. Every output is registered.
// Optional feature: define BSM_SER_WIDTH_CHECK_EN to reject handshakes whose
// widths are 0 or above MAXW (err pulse, nothing latched).
module bsm_operand_serializer #(
  parameter int unsigned MAXW = 16
) (
  input logic                   clk,
  input logic                   rst,
  bsm_operand_serializer_if.slave bus
);

  localparam logic [4:0] MaxW5 = 5'(MAXW);

  typedef enum logic [1:0] {StIdle, StStart, StSend} state_e;

  state_e          state_q;
  logic [MAXW-1:0] a_q;
  logic [MAXW-1:0] b_q;
  logic [4:0]      wa_q;
  logic [4:0]      wb_q;
  logic [4:0]      maxw_q;
  // Index of the next bit to be driven onto the serial outputs.
  logic [4:0]      cnt_q;
  logic            in_ready_q;
  logic            start_q;
  logic            bit_a_q;
  logic            bit_b_q;
  logic            last_q;
  logic            busy_q;
  logic [4:0]      in_maxw;
  logic            width_ok;

  // Sign-extending bit select: positions at or above the width repeat the
  // sign bit; anything outside the register reads as 0.
  function automatic logic sel_bit(input logic [MAXW-1:0] d, input logic [4:0] w,
                                   input logic [4:0] idx);
    logic [4:0] p;
    logic       r;
    p = (idx < w) ? idx : (w - 5'd1);
    r = 1'b0;
    for (int unsigned i = 0; i < MAXW; i++) begin
      if (p == 5'(i)) r = d[i];
    end
    return r;
  endfunction

  // Stream length for the offered pair; zero widths still take one bit cycle.
  always_comb begin
    in_maxw = (bus.wa > bus.wb) ? bus.wa : bus.wb;
    if (in_maxw == 5'd0) in_maxw = 5'd1;
  end

`ifdef BSM_SER_WIDTH_CHECK_EN
  logic err_q;

  // Legal widths are 1..MAXW for both operands.
  always_comb begin
    width_ok = (bus.wa != 5'd0) && (bus.wb != 5'd0) && (bus.wa <= MaxW5) && (bus.wb <= MaxW5);
  end

  assign bus.err = err_q;
`else
  always_comb begin
    width_ok = 1'b1;
  end

  assign bus.err = 1'b0;
`endif

  // Handshake / start / send sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      wa_q       <= '0;
      wb_q       <= '0;
      maxw_q     <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      bit_a_q    <= 1'b0;
      bit_b_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef BSM_SER_WIDTH_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
`ifdef BSM_SER_WIDTH_CHECK_EN
      err_q   <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          bit_a_q <= 1'b0;
          bit_b_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          if (in_ready_q && bus.in_valid) begin
            // Any accepted handshake drops ready; a rejected one only for a cycle.
            in_ready_q <= 1'b0;
            if (width_ok) begin
              a_q     <= bus.a_data;
              b_q     <= bus.b_data;
              wa_q    <= bus.wa;
              wb_q    <= bus.wb;
              maxw_q  <= in_maxw;
              cnt_q   <= 5'd0;
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= StStart;
            end
`ifdef BSM_SER_WIDTH_CHECK_EN
            else begin
              err_q <= 1'b1;
            end
`endif
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        StStart: begin
          bit_a_q <= sel_bit(a_q, wa_q, 5'd0);
          bit_b_q <= sel_bit(b_q, wb_q, 5'd0);
          last_q  <= (maxw_q == 5'd1);
          cnt_q   <= 5'd1;
          state_q <= StSend;
        end

        StSend: begin
          if (last_q) begin
            bit_a_q    <= 1'b0;
            bit_b_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            cnt_q      <= 5'd0;
            state_q    <= StIdle;
          end else begin
            bit_a_q <= sel_bit(a_q, wa_q, cnt_q);
            bit_b_q <= sel_bit(b_q, wb_q, cnt_q);
            last_q  <= (cnt_q == (maxw_q - 5'd1));
            cnt_q   <= cnt_q + 5'd1;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.start    = start_q;
  assign bus.wa_out   = wa_q;
  assign bus.wb_out   = wb_q;
  assign bus.bit_a    = bit_a_q;
  assign bus.bit_b    = bit_b_q;
  assign bus.last     = last_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_bsm_operand_serializer.sv
// Self-checking bench for bsm_operand_serializer: a cycle-indexed expectation
// table filled from the transaction rules, compared against the DUT every cycle.
module tb_bsm_operand_serializer;

  localparam int unsigned MAXW = 16;
  localparam int N = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bsm_operand_serializer_if #(.MAXW(MAXW)) bus ();

  bsm_operand_serializer #(.MAXW(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = -1;
  int hs_count = 0;
  int hs_edge[$];

  logic       exp_ready[N];
  logic       exp_start[N];
  logic       exp_a[N];
  logic       exp_amask[N];
  logic       exp_b[N];
  logic       exp_bmask[N];
  logic       exp_last[N];
  logic       exp_busy[N];
  logic       exp_err[N];
  logic [4:0] exp_wa[N];
  logic [4:0] exp_wb[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d, t=%0t)", name, act, req, cyc, $time);
    end
  endtask

  // Bit i of the operand interpreted as a w-bit two's complement integer.
  function automatic logic sbit(input logic [MAXW-1:0] d, input int w, input int i);
    longint v;
    longint s;
    v = 0;
    for (int k = 0; k < w; k++) v = v + (longint'(d[k]) << k);
    if (d[w-1]) v = v - (longint'(1) << w);
    s = v >>> i;
    return s[0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      exp_ready[i] = 1'b1;
      exp_start[i] = 1'b0;
      exp_a[i]     = 1'b0;
      exp_amask[i] = 1'b1;
      exp_b[i]     = 1'b0;
      exp_bmask[i] = 1'b1;
      exp_last[i]  = 1'b0;
      exp_busy[i]  = 1'b0;
      exp_err[i]   = 1'b0;
      exp_wa[i]    = 5'd0;
      exp_wb[i]    = 5'd0;
    end
  endtask

  // Fill the table for a handshake accepted at edge e.
  task automatic sched(input int e, input logic [MAXW-1:0] a, input logic [MAXW-1:0] b,
                       input int x, input int y);
    int m;
`ifdef BSM_SER_WIDTH_CHECK_EN
    if (x == 0 || y == 0 || x > MAXW || y > MAXW) begin
      exp_ready[e] = 1'b0;
      exp_err[e]   = 1'b1;
      return;
    end
`endif
    m = (x > y) ? x : y;
    if (m == 0) m = 1;
    exp_start[e] = 1'b1;
    for (int c = e; c <= e + m && c < N; c++) begin
      exp_busy[c]  = 1'b1;
      exp_ready[c] = 1'b0;
    end
    for (int i = 0; i < m && e + 1 + i < N; i++) begin
      exp_amask[e+1+i] = (x >= 1 && x <= MAXW);
      exp_bmask[e+1+i] = (y >= 1 && y <= MAXW);
      exp_a[e+1+i] = exp_amask[e+1+i] ? sbit(a, x, i) : 1'b0;
      exp_b[e+1+i] = exp_bmask[e+1+i] ? sbit(b, y, i) : 1'b0;
    end
    if (e + m < N) exp_last[e+m] = 1'b1;
    for (int c = e; c < N; c++) begin
      exp_wa[c] = 5'(x);
      exp_wb[c] = 5'(y);
    end
  endtask

  // Model: detect handshakes from the model's own ready and advance the cycle.
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
      cyc = -1;
    end else begin
      if (cyc >= 0 && cyc < N - 1 && bus.in_valid && exp_ready[cyc]) begin
        sched(cyc + 1, bus.a_data, bus.b_data, int'(bus.wa), int'(bus.wb));
        hs_count++;
        hs_edge.push_back(cyc + 1);
      end
      cyc++;
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clk) begin
    if (rst || cyc < 0) begin
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_start", 32'(bus.start), 0);
      chk("rst_bit_a", 32'(bus.bit_a), 0);
      chk("rst_bit_b", 32'(bus.bit_b), 0);
      chk("rst_last", 32'(bus.last), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_wa_out", 32'(bus.wa_out), 0);
      chk("rst_wb_out", 32'(bus.wb_out), 0);
    end else if (cyc < N) begin
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready[cyc]));
      chk("start", 32'(bus.start), 32'(exp_start[cyc]));
      if (exp_amask[cyc]) chk("bit_a", 32'(bus.bit_a), 32'(exp_a[cyc]));
      if (exp_bmask[cyc]) chk("bit_b", 32'(bus.bit_b), 32'(exp_b[cyc]));
      chk("last", 32'(bus.last), 32'(exp_last[cyc]));
      chk("busy", 32'(bus.busy), 32'(exp_busy[cyc]));
      chk("err", 32'(bus.err), 32'(exp_err[cyc]));
      chk("wa_out", 32'(bus.wa_out), 32'(exp_wa[cyc]));
      chk("wb_out", 32'(bus.wb_out), 32'(exp_wb[cyc]));
    end
  end

  task automatic wait_hs(input int target);
    for (int t = 0; t < 100 && hs_count < target; t++) begin
      @(posedge clk);
      #1;
    end
    if (hs_count < target) chk("hs_timeout", 32'(hs_count), 32'(target));
  endtask

  task automatic drive(input logic [MAXW-1:0] a, input logic [MAXW-1:0] b,
                       input logic [4:0] x, input logic [4:0] y);
    bus.a_data = a;
    bus.b_data = b;
    bus.wa     = x;
    bus.wb     = y;
  endtask

  task automatic send(input logic [MAXW-1:0] a, input logic [MAXW-1:0] b,
                      input logic [4:0] x, input logic [4:0] y, output int e);
    int target;
    target = hs_count + 1;
    bus.in_valid = 1'b1;
    drive(a, b, x, y);
    wait_hs(target);
    e = hs_edge[$];
    bus.in_valid = 1'b0;
    drive('0, '0, 5'd0, 5'd0);
    repeat (int'((x > y) ? x : y) + 3) @(posedge clk);
    #1;
  endtask

  // Pin the model's stream for one transaction against hand-computed literals.
  task automatic pin(input string name, input int e, input int m,
                     input logic [31:0] lit_a, input logic [31:0] lit_b);
    logic [31:0] va;
    logic [31:0] vb;
    va = '0;
    vb = '0;
    for (int i = 0; i < m; i++) begin
      va[i] = exp_a[e+1+i];
      vb[i] = exp_b[e+1+i];
    end
    chk({name, "_a_stream"}, va, lit_a);
    chk({name, "_b_stream"}, vb, lit_b);
    chk({name, "_start"}, 32'(exp_start[e]), 1);
    chk({name, "_last"}, 32'(exp_last[e+m]), 1);
    chk({name, "_ready_after"}, 32'(exp_ready[e+m+1]), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int e;
    int base;
    logic [MAXW-1:0] pa[3];
    logic [MAXW-1:0] pb[3];
    pa[0] = 16'h005A; pa[1] = 16'h0081; pa[2] = 16'h00FF;
    pb[0] = 16'h00C3; pb[1] = 16'h007E; pb[2] = 16'h0001;

    rst = 1'b0;
    bus.in_valid = 1'b0;
    drive('0, '0, 5'd0, 5'd0);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic 4x4: A=-3, B=5.
    send(16'h000D, 16'h0005, 5'd4, 5'd4, e);
    pin("basic", e, 4, 32'b1101, 32'b0101);

    // Unequal widths: A=3'b110, B=5'b01001; upper bits of data are garbage.
    send(16'hFFFE, 16'hFFE9, 5'd3, 5'd5, e);
    pin("unequal", e, 5, 32'b11110, 32'b01001);
    chk("unequal_wa_held", 32'(exp_wa[e+5]), 3);

    // Width-1 A=1 (-1), B=4'b0111.
    send(16'h0001, 16'h0007, 5'd1, 5'd4, e);
    pin("width1", e, 4, 32'b1111, 32'b0111);

    // Back-to-back with in_valid held high and junk offered during SEND.
    base = hs_count;
    bus.in_valid = 1'b1;
    drive(pa[0], pb[0], 5'd8, 5'd8);
    for (int j = 0; j < 3; j++) begin
      wait_hs(base + j + 1);
      @(posedge clk);
      #1 drive(16'hA5A5, 16'h5A5A, 5'd3, 5'd2);
      repeat (6) @(posedge clk);
      #1;
      if (j < 2) drive(pa[j+1], pb[j+1], 5'd8, 5'd8);
      else bus.in_valid = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_count", 32'(hs_count - base), 3);
    chk("b2b_gap1", 32'(hs_edge[$-1] - hs_edge[$-2]), 10);
    chk("b2b_gap2", 32'(hs_edge[$] - hs_edge[$-1]), 10);
    pin("b2b_last", hs_edge[$], 8, 32'hFF, 32'h01);

    // Reset during the 3rd bit of a 6x6 transfer.
    bus.in_valid = 1'b1;
    drive(16'h002D, 16'h0013, 5'd6, 5'd6);
    wait_hs(hs_count + 1);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'h002D, 16'h0013, 5'd6, 5'd6, e);
    pin("after_rst", e, 6, 32'b101101, 32'b010011);

    // Zero width on A: rejected with err when checking is built in.
    send(16'h0000, 16'h0003, 5'd0, 5'd4, e);
`ifdef BSM_SER_WIDTH_CHECK_EN
    chk("zero_w_err", 32'(exp_err[e]), 1);
    chk("zero_w_nostart", 32'(exp_start[e]), 0);
`else
    chk("zero_w_start", 32'(exp_start[e]), 1);
`endif
    send(16'h0002, 16'h000E, 5'd2, 5'd4, e);
    pin("after_zero", e, 4, 32'b1110, 32'b1110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
